// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and bit-timing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Offset from a start edge to the middle of the bit.
    function automatic int bit_delay_mid(input int clocks_per_bit);
        return clocks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/simple_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Define SIMPLE_RX_ERR_EN to add the frame_err_o / overrun_o pulse outputs.
module simple_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 16
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       in_i,
`ifdef SIMPLE_RX_ERR_EN
    output logic       frame_err_o,
    output logic       overrun_o,
`endif
    output logic [7:0] out_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);

    localparam logic [7:0] DLY_MID_M1 = 8'(bit_delay_mid(clocks_per_bit) - 1);
    localparam logic [7:0] DLY_MAX    = 8'(clocks_per_bit - 1);
    // Wide enough to index every bit position of a frame.
    localparam int         CNT_W      = $clog2(UART_FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(UART_DATA_BITS - 1);

    logic             rxs;
    rx_state_t        state_q;
    logic [7:0]       delay_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       shift_q;
    logic [7:0]       out_q;
    logic             out_valid_q;
`ifdef SIMPLE_RX_ERR_EN
    logic             frame_err_q;
    logic             overrun_q;
`endif

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clock_i),
        .rst_i (reset_i),
        .d_i   (in_i),
        .q_o   (rxs)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            delay_q     <= '0;
            count_q     <= '0;
            shift_q     <= 8'h00;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
`ifdef SIMPLE_RX_ERR_EN
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`endif
        end else begin
`ifdef SIMPLE_RX_ERR_EN
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`endif
            // A load in STOP below overrides this clear on a simultaneous handshake.
            if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        delay_q <= '0;
                    end
                end
                START: begin
                    if (delay_q == DLY_MID_M1) begin
                        if (rxs) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            delay_q <= '0;
                            count_q <= '0;
                        end
                    end else begin
                        delay_q <= delay_q + 8'd1;
                    end
                end
                DATA: begin
                    if (delay_q == DLY_MAX) begin
                        shift_q <= {rxs, shift_q[7:1]};
                        count_q <= count_q + CNT_W'(1);
                        delay_q <= '0;
                        if (count_q == LAST_DATA) state_q <= STOP;
                    end else begin
                        delay_q <= delay_q + 8'd1;
                    end
                end
                STOP: begin
                    if (delay_q == DLY_MAX) begin
                        delay_q <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                            if (!out_valid_q || out_ready_i) begin
                                out_q       <= shift_q;
                                out_valid_q <= 1'b1;
                            end
`ifdef SIMPLE_RX_ERR_EN
                            else overrun_q <= 1'b1;
`endif
                        end else begin
                            state_q <= BREAK;
`ifdef SIMPLE_RX_ERR_EN
                            frame_err_q <= 1'b1;
`endif
                        end
                    end else begin
                        delay_q <= delay_q + 8'd1;
                    end
                end
                BREAK: begin
                    if (rxs) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
`ifdef SIMPLE_RX_ERR_EN
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`endif

endmodule

// File: tb/tb_simple_rx.sv
// Directed bench for simple_rx at clocks_per_bit=4; a line model plays the transmitter.
module tb_simple_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       in_i;
    logic [7:0] out_o;
    logic       out_valid_o;
    logic       out_ready_i;
`ifdef SIMPLE_RX_ERR_EN
    logic       frame_err_o;
    logic       overrun_o;
`endif

    simple_rx #(.clocks_per_bit(CPB)) dut (
        .clock_i     (clk),
        .reset_i     (reset_i),
        .in_i        (in_i),
`ifdef SIMPLE_RX_ERR_EN
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
`endif
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         rise_cyc = -1;
    int         vld_cycles = 0;
    int         stab_err = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] rxq[$];
    logic       vld_prev = 1'b0;
    logic       hs_prev = 1'b0;
    logic [7:0] out_prev = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples on the falling edge; inputs change 2 time units after the rising edge.
    always @(negedge clk) begin
        if (out_valid_o && !vld_prev) rise_cyc = cyc;
        if (out_valid_o) vld_cycles++;
        if (out_valid_o && out_ready_i) rxq.push_back(out_o);
        if (vld_prev && !hs_prev && out_valid_o && out_o !== out_prev) stab_err++;
`ifdef SIMPLE_RX_ERR_EN
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
`endif
        vld_prev = out_valid_o;
        hs_prev  = out_valid_o && out_ready_i;
        out_prev = out_o;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the first nbits bit-times of a frame: start, 8 data LSB first, stop.
    task automatic send_bits(input logic [7:0] b, input logic stop, input int nbits);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < nbits; i++) begin
            in_i = fr[i];
            ticks(CPB);
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b1, 10);
    endtask

    initial begin
        reset_i     = 1'b1;
        in_i        = 1'b1;
        out_ready_i = 1'b1;
        ticks(3);
        chk("reset_out", 32'(out_o), 32'h00);
        chk("reset_valid", 32'(out_valid_o), 32'h0);
`ifdef SIMPLE_RX_ERR_EN
        chk("reset_errs", 32'({frame_err_o, overrun_o}), 32'h0);
`endif
        reset_i = 1'b0;
        ticks(4);

        // Single byte with latency and pulse width.
        rxq.delete();
        vld_cycles = 0;
        send(8'h55);
        ticks(8);
        chk("single_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("single_data", 32'(rxq[0]), 32'h55);
        chk("single_latency", 32'(rise_cyc - t0), 32'd41);
        chk("single_pulse", 32'(vld_cycles), 32'd1);

        // Back-to-back frames, no idle gap.
        rxq.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        send(8'h3C);
        ticks(8);
        chk("b2b_count", 32'(rxq.size()), 32'd4);
        if (rxq.size() == 4) begin
            chk("b2b_0", 32'(rxq[0]), 32'h00);
            chk("b2b_1", 32'(rxq[1]), 32'hFF);
            chk("b2b_2", 32'(rxq[2]), 32'hA5);
            chk("b2b_3", 32'(rxq[3]), 32'h3C);
        end
`ifdef SIMPLE_RX_ERR_EN
        chk("b2b_errs", 32'(fe_cnt + ov_cnt), 32'd0);
`endif

        // Overrun: second byte dropped while the first is held.
        rxq.delete();
        out_ready_i = 1'b0;
        send(8'h12);
        send(8'h34);
        ticks(8);
        chk("ovr_valid", 32'(out_valid_o), 32'h1);
        chk("ovr_held", 32'(out_o), 32'h12);
`ifdef SIMPLE_RX_ERR_EN
        chk("ovr_pulse", 32'(ov_cnt), 32'd1);
`endif
        out_ready_i = 1'b1;
        ticks(3);
        chk("ovr_drain_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("ovr_drain_data", 32'(rxq[0]), 32'h12);
        chk("ovr_drain_valid", 32'(out_valid_o), 32'h0);

        // One-cycle glitch is rejected at mid-start.
        rxq.delete();
        in_i = 1'b0;
        tick();
        in_i = 1'b1;
        ticks(12 * CPB);
        chk("glitch_none", 32'(rxq.size()), 32'd0);

        // Stop bit forced low.
        fe_cnt = 0;
        send_bits(8'hAA, 1'b0, 10);
        in_i = 1'b1;
        ticks(4 * CPB);
        chk("ferr_none", 32'(rxq.size()), 32'd0);
`ifdef SIMPLE_RX_ERR_EN
        chk("ferr_pulse", 32'(fe_cnt), 32'd1);
`endif

        // Break: line low for three frame times.
        in_i = 1'b0;
        ticks(30 * CPB);
        chk("break_none", 32'(rxq.size()), 32'd0);
        in_i = 1'b1;
        ticks(2 * CPB);
        send(8'h7E);
        ticks(8);
        chk("break_recover_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("break_recover_data", 32'(rxq[0]), 32'h7E);

        // Reset during data bit 4, with a byte held in the buffer.
        rxq.delete();
        out_ready_i = 1'b0;
        send(8'h5A);
        ticks(8);
        chk("pre_reset_held", 32'(out_o), 32'h5A);
        send_bits(8'hC3, 1'b1, 5);
        in_i = 1'b0;
        ticks(2);
        reset_i = 1'b1;
        #1;
        chk("async_reset_out", 32'(out_o), 32'h00);
        chk("async_reset_valid", 32'(out_valid_o), 32'h0);
        in_i = 1'b1;
        ticks(3);
        reset_i = 1'b0;
        out_ready_i = 1'b1;
        ticks(4);
        send(8'h81);
        ticks(8);
        chk("post_reset_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("post_reset_data", 32'(rxq[0]), 32'h81);

        // Handshake on the same edge as the stop-bit sample.
        rxq.delete();
        ov_cnt = 0;
        out_ready_i = 1'b0;
        send(8'h11);
        ticks(8);
        send(8'h99);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        ticks(2);
        chk("simul_valid", 32'(out_valid_o), 32'h1);
        chk("simul_data", 32'(out_o), 32'h99);
        chk("simul_old", 32'(rxq.size()), 32'd1);
`ifdef SIMPLE_RX_ERR_EN
        chk("simul_no_ovr", 32'(ov_cnt), 32'd0);
`endif
        out_ready_i = 1'b1;
        ticks(3);
        chk("simul_drain_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) chk("simul_drain_data", 32'(rxq[1]), 32'h99);
        chk("simul_drain_valid", 32'(out_valid_o), 32'h0);

        chk("out_stable", 32'(stab_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
